// File: rtl/fakeram7_bist_pkg.sv
// rtl/fakeram7_bist_pkg.sv - march C- element table shared by the MBIST sequencer and checker
package fakeram7_bist_pkg;

    localparam int NUM_ELEMS = 6;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // rd_val / wr_val: 0 selects the data background, 1 its complement
    typedef struct packed {
        logic down;
        logic has_read;
        logic rd_val;
        logic has_write;
        logic wr_val;
    } elem_attr_t;

    localparam elem_attr_t ELEM_ATTR [NUM_ELEMS] = '{
        '{down: 1'b0, has_read: 1'b0, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b0},
        '{down: 1'b0, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b1},
        '{down: 1'b0, has_read: 1'b1, rd_val: 1'b1, has_write: 1'b1, wr_val: 1'b0},
        '{down: 1'b1, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b1},
        '{down: 1'b1, has_read: 1'b1, rd_val: 1'b1, has_write: 1'b1, wr_val: 1'b0},
        '{down: 1'b1, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b0, wr_val: 1'b0}
    };

endpackage

// File: rtl/fakeram7_bist_checker.sv
// rtl/fakeram7_bist_checker.sv - one-cycle read compare, first-fail capture and saturating fail count
module fakeram7_bist_checker #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [BITS-1:0]       exp_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            elem_i,
    input  logic                  pass_i,
    input  logic [BITS-1:0]       rd_a_i,
    input  logic [BITS-1:0]       rd_b_i,
    output logic                  fail_o,
    output logic [7:0]            fail_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic                  fail_pass_o,
    output logic [BITS-1:0]       fail_syn_o
);

    logic                  valid_q;
    logic [BITS-1:0]       exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            elem_q;
    logic                  pass_q;

    logic                  fail_q;
    logic [7:0]            count_q;
    logic [ADDR_WIDTH-1:0] faddr_q;
    logic [2:0]            felem_q;
    logic                  fpass_q;
    logic [BITS-1:0]       fsyn_q;

    logic [BITS-1:0] rd_sel;
    logic [BITS-1:0] syn;
    logic            miscmp;

    // pass 0 writes on A and reads on B; pass 1 is the mirror image
    assign rd_sel = pass_q ? rd_a_i : rd_b_i;
    assign syn    = rd_sel ^ exp_q;
    assign miscmp = valid_q && (syn != '0);

    always_ff @(posedge clk) begin
        if (rst_i || clear_i) begin
            valid_q <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            elem_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            count_q <= '0;
            faddr_q <= '0;
            felem_q <= '0;
            fpass_q <= 1'b0;
            fsyn_q  <= '0;
        end else begin
            valid_q <= valid_i;
            exp_q   <= exp_i;
            addr_q  <= addr_i;
            elem_q  <= elem_i;
            pass_q  <= pass_i;
            if (miscmp) begin
                if (!fail_q) begin
                    fail_q  <= 1'b1;
                    faddr_q <= addr_q;
                    felem_q <= elem_q;
                    fpass_q <= pass_q;
                    fsyn_q  <= syn;
                end
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end
        end
    end

    assign fail_o       = fail_q;
    assign fail_count_o = count_q;
    assign fail_addr_o  = faddr_q;
    assign fail_elem_o  = felem_q;
    assign fail_pass_o  = fpass_q;
    assign fail_syn_o   = fsyn_q;

endmodule

// File: rtl/fakeram7_dp_mbist.sv
// rtl/fakeram7_dp_mbist.sv - dual-port march C- MBIST sequencer driving both fakeram7 ports
module fakeram7_dp_mbist
    import fakeram7_bist_pkg::*;
#(
    parameter int              BITS       = 32,
    parameter int              WORD_DEPTH = 64,
    parameter int              ADDR_WIDTH = 6,
    parameter logic [BITS-1:0] DATA_BG    = '0
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  fail_out,
    output logic [7:0]            fail_count_out,
    output logic [ADDR_WIDTH-1:0] fail_addr_out,
    output logic [2:0]            fail_elem_out,
    output logic                  fail_pass_out,
    output logic [BITS-1:0]       fail_syn_out,
    output logic                  ram_ce_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_A_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_B_out,
    output logic                  ram_we_A_out,
    output logic                  ram_we_B_out,
    output logic [BITS-1:0]       ram_wd_A_out,
    output logic [BITS-1:0]       ram_wd_B_out,
    output logic [BITS-1:0]       ram_w_mask_A_out,
    output logic [BITS-1:0]       ram_w_mask_B_out,
    input  logic [BITS-1:0]       ram_rd_A_in,
    input  logic [BITS-1:0]       ram_rd_B_in
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    elem_e                 elem_q, elem_d, elem_nx;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic            ce_q, we_a_q, we_b_q;
    logic [BITS-1:0] wd_a_q, wd_b_q, mask_a_q, mask_b_q;

    logic            start_ok;
    logic            elem_last;
    logic            run_d, wr_a_d, wr_b_d;
    logic [BITS-1:0] wval_d;
    logic            chk_valid;
    logic [BITS-1:0] chk_exp;

    assign start_ok  = start_in && (state_q == S_IDLE || state_q == S_DONE);
    assign elem_last = ELEM_ATTR[elem_q].down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign elem_nx   = elem_e'(elem_q + 3'd1);

    // Element and pass boundaries load the next start address directly so commands never gap
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        pass_d  = pass_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    state_d = S_RUN;
                    elem_d  = M0;
                    pass_d  = 1'b0;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (!elem_last) begin
                    addr_d = ELEM_ATTR[elem_q].down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                end else if (elem_q != M5) begin
                    elem_d = elem_nx;
                    addr_d = ELEM_ATTR[elem_nx].down ? ADDR_LAST : '0;
                end else if (!pass_q) begin
                    pass_d = 1'b1;
                    elem_d = M0;
                    addr_d = '0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign run_d  = (state_d == S_RUN);
    assign wr_a_d = run_d && ELEM_ATTR[elem_d].has_write && !pass_d;
    assign wr_b_d = run_d && ELEM_ATTR[elem_d].has_write && pass_d;
    assign wval_d = ELEM_ATTR[elem_d].wr_val ? ~DATA_BG : DATA_BG;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            elem_q   <= M0;
            pass_q   <= 1'b0;
            addr_q   <= '0;
            ce_q     <= 1'b0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            wd_a_q   <= '0;
            wd_b_q   <= '0;
            mask_a_q <= '0;
            mask_b_q <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            pass_q   <= pass_d;
            addr_q   <= addr_d;
            ce_q     <= run_d;
            we_a_q   <= wr_a_d;
            we_b_q   <= wr_b_d;
            wd_a_q   <= wr_a_d ? wval_d : '0;
            wd_b_q   <= wr_b_d ? wval_d : '0;
            mask_a_q <= wr_a_d ? '1 : '0;
            mask_b_q <= wr_b_d ? '1 : '0;
        end
    end

    assign chk_valid = (state_q == S_RUN) && ELEM_ATTR[elem_q].has_read;
    assign chk_exp   = ELEM_ATTR[elem_q].rd_val ? ~DATA_BG : DATA_BG;

    fakeram7_bist_checker #(
        .BITS       (BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_checker (
        .clk          (clk),
        .rst_i        (rst_in),
        .clear_i      (start_ok),
        .valid_i      (chk_valid),
        .exp_i        (chk_exp),
        .addr_i       (addr_q),
        .elem_i       (elem_q),
        .pass_i       (pass_q),
        .rd_a_i       (ram_rd_A_in),
        .rd_b_i       (ram_rd_B_in),
        .fail_o       (fail_out),
        .fail_count_o (fail_count_out),
        .fail_addr_o  (fail_addr_out),
        .fail_elem_o  (fail_elem_out),
        .fail_pass_o  (fail_pass_out),
        .fail_syn_o   (fail_syn_out)
    );

    assign busy_out         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_out         = (state_q == S_DONE);
    assign ram_ce_out       = ce_q;
    assign ram_addr_A_out   = addr_q;
    assign ram_addr_B_out   = addr_q;
    assign ram_we_A_out     = we_a_q;
    assign ram_we_B_out     = we_b_q;
    assign ram_wd_A_out     = wd_a_q;
    assign ram_wd_B_out     = wd_b_q;
    assign ram_w_mask_A_out = mask_a_q;
    assign ram_w_mask_B_out = mask_b_q;

endmodule

// File: doc/fakeram7_dp_mbist.md
Name: fakeram7_dp_mbist

Overview:
- March C- memory built-in self-test initiator for the dual-port fakeram7 macros; it drives both RAM ports and checks the read data.
- Pass 0 writes through port A and reads through port B. Pass 1 swaps the roles.
- Sits beside each dual-port fakeram7 instance. It runs under SoC test control; functional logic is muxed onto the RAM ports outside this block.

Parameters:
- BITS, 32, RAM word width
- WORD_DEPTH, 64, RAM words
- ADDR_WIDTH, 6, log2(WORD_DEPTH)
- DATA_BG, 32'h0, data background; "0" = DATA_BG, "1" = ~DATA_BG

Ports:
- clk  in  1  clock; all logic is on its rising edge
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  start pulse, sampled only when not busy
- busy_out  out  1  test running, including the drain cycle
- done_out  out  1  sticky; test complete
- fail_out  out  1  sticky; at least one miscompare
- fail_count_out  out  8  miscompare count, saturates at 255
- fail_addr_out  out  ADDR_WIDTH  address of first miscompare
- fail_elem_out  out  3  march element (0-5) of first miscompare
- fail_pass_out  out  1  pass of first miscompare
- fail_syn_out  out  BITS  first miscompare syndrome: read XOR expected
- ram_ce_out  out  1  RAM chip enable
- ram_addr_A_out / ram_addr_B_out  out  ADDR_WIDTH  port addresses
- ram_we_A_out / ram_we_B_out  out  1  port write enables
- ram_wd_A_out / ram_wd_B_out  out  BITS  port write data
- ram_w_mask_A_out / ram_w_mask_B_out  out  BITS  port write masks
- ram_rd_A_in / ram_rd_B_in  in  BITS  port read data; valid the cycle after the command edge

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE. Applies from any state, including mid-test; the next cycle shows ce=0 and we=0.
- FSM states:
  - IDLE: start_in=1 → RUN at elem 0, pass 0, addr 0.
  - RUN: issues one RAM command per cycle.
  - DRAIN: one cycle for the final compare.
  - DONE: start_in=1 → RUN, clearing done, fail and all fail fields.
- start_in is ignored in RUN and DRAIN.
- March elements, each covering all addresses:
  - M0 up: w0
  - M1 up: r0,w1
  - M2 up: r1,w0
  - M3 down: r0,w1
  - M4 down: r1,w0
  - M5 down: r0
- Read-then-write is done in one cycle: the write port and read port are given the same address. The RAM returns the pre-write word.
- Command timing:
  - Command outputs are registered.
  - The first command is presented in the cycle after the start edge.
  - There are no gaps between elements or between passes: 6*WORD_DEPTH commands per pass, 2*6*WORD_DEPTH commands total.
- Address sequencing:
  - Up elements run 0→WORD_DEPTH-1; down elements run WORD_DEPTH-1→0.
  - The boundary cycle loads the next element's start address.
- Both address ports always carry the current address, so RAM addresses are never X.
- In RUN:
  - ram_ce_out = 1.
  - The write port has we=1 and w_mask all-ones in write cycles.
  - The idle port has we=0 and w_mask=0.
  - wd carries the element's write value, or 0 when not writing.
- Outside RUN: ce=0, we=0, mask=0.
- Compare pipeline:
  - Expected value, address, elem, pass and a valid bit are delayed 1 cycle.
  - The compare uses the read port of the delayed pass.
  - Miscompare = valid && (rd != expected).
- Fail capture:
  - The first miscompare latches the fail fields.
  - fail_count increments on every miscompare, saturating at 255.
  - The test always runs to completion.
- Completion:
  - After the last command, one DRAIN cycle, then DONE.
  - busy_out falls and done_out rises together, 12*WORD_DEPTH+1 edges after the start edge (769 at default).
  - The final compare's fail update is visible in that same cycle.

Decomposition:
- fakeram7_bist_pkg holds:
  - element enum M0..M5
  - constant per-element attribute table: direction, has_read, read value, has_write, write value
  - NUM_ELEMS = 6
- Sub-module fakeram7_bist_checker holds the 1-cycle compare pipeline, fail capture and saturating counter.
- The FSM and address generator stay in the top level.

Test Plan:
1. Clean behavioural RAM, start pulse:
   - busy high for 769 cycles, then done=1, fail=0, fail_count=0.
   - Final RAM contents all DATA_BG.
2. RAM model with bit 5 of address 0x2A stuck-at-0:
   - fail=1, fail_addr=0x2A, fail_elem=2, fail_pass=0, fail_syn=32'h20.
   - fail_count=4 (M2 and M4 fail in each pass).
3. RAM model ignoring port-B writes:
   - fail_pass=1, fail_addr=0, fail_elem=2, fail_syn=32'hFFFFFFFF.
   - fail_count=128; pass 0 is clean.
4. Assert rst_in at cycle 100 of a run:
   - next cycle: all outputs 0, ce=0.
   - A new start completes clean at 769 edges.
5. start_in held high throughout:
   - Restarts are ignored while busy.
   - On the cycle after done, a new run begins with done and fail cleared.
   - Back-to-back runs give identical results.
6. Address monitor:
   - M0-M2 ascend 0..63 and M3-M5 descend 63..0.
   - Element boundaries go 63→63 (M2→M3) and 0→0 (M4→M5), with ce continuously high across all 768 commands.
